// File: rtl/com_pkg.sv
// Shared definitions for the serial-port receive path.
// Holds the byte width, the default FIFO depth and the CPU status-word bit positions.
package com_pkg;

  localparam int COM_BYTE_W        = 8;
  localparam int COM_DEPTH_LOG_DEF = 4;

  // Bit positions inside the CPU-visible status word
  localparam int STAT_DATA_AVAIL_BIT = 0;
  localparam int STAT_FULL_BIT       = 1;
  localparam int STAT_OVERRUN_BIT    = 2;
  localparam int STAT_IRQ_BIT        = 3;

  // Assemble the status word the bus-side register presents to the CPU
  function automatic logic [COM_BYTE_W-1:0] com_status_word(
    input logic data_avail,
    input logic full,
    input logic overrun,
    input logic irq
  );
    logic [COM_BYTE_W-1:0] w;
    w                      = '0;
    w[STAT_DATA_AVAIL_BIT] = data_avail;
    w[STAT_FULL_BIT]       = full;
    w[STAT_OVERRUN_BIT]    = overrun;
    w[STAT_IRQ_BIT]        = irq;
    return w;
  endfunction

endpackage

// File: rtl/com_rx_fifo_ram.sv
// Receive FIFO storage: registered write port, asynchronous read port.
// Contents are deliberately not reset so the array maps onto distributed RAM.
module com_rx_fifo_ram
  import com_pkg::*;
#(
  parameter int ADDR_W = COM_DEPTH_LOG_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [COM_BYTE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [COM_BYTE_W-1:0] rd_data
);

  logic [COM_BYTE_W-1:0] mem [(1 << ADDR_W)];

  // Write the incoming byte on the clock edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/com_rx_buffer.sv
// Receive buffer between the UART receiver and the CPU serial port.
// Circular FIFO with sticky overrun flag. Optional level interrupt is built
// only when COM_RX_IRQ_EN is defined; otherwise irq is tied low.
module com_rx_buffer
  import com_pkg::*;
#(
  parameter int DEPTH_LOG    = COM_DEPTH_LOG_DEF,
  parameter int IRQ_THRESH   = 8,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_strobe,
  input  logic [COM_BYTE_W-1:0] rx_data,
  input  logic                  rd_pop,
  input  logic                  ovr_clr,
  output logic [COM_BYTE_W-1:0] rd_data,
  output logic                  data_avail,
  output logic                  full,
  output logic [DEPTH_LOG:0]    level,
  output logic                  overrun,
  output logic                  irq
);

  localparam int unsigned       DEPTH     = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_CNT = DEPTH[DEPTH_LOG:0];

  logic [DEPTH_LOG-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]    count_q,  count_d;
  logic                  overrun_q, overrun_d;
  logic                  is_full, is_empty;
  logic                  push, pop, ovr_evt;
  logic [COM_BYTE_W-1:0] ram_rd_data;

  assign is_full  = (count_q == DEPTH_CNT);
  assign is_empty = (count_q == '0);

  // A full FIFO still accepts a byte when the CPU pops in the same cycle;
  // a pop on an empty FIFO never consumes the byte being pushed.
  assign push    = rx_strobe && (!is_full || rd_pop);
  assign pop     = rd_pop && !is_empty;
  assign ovr_evt = rx_strobe && is_full && !rd_pop;

  // Next-state for pointers, count and the sticky overrun flag
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (ovr_evt)      overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  // FIFO bookkeeping registers; reset drops all buffered bytes at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  com_rx_fifo_ram #(
    .ADDR_W (DEPTH_LOG)
  ) u_ram (
    .clk     (clk),
    .we      (push && !rst),
    .wr_addr (wr_ptr_q),
    .wr_data (rx_data),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  assign rd_data    = is_empty ? '0 : ram_rd_data;
  assign data_avail = !is_empty;
  assign full       = is_full;
  assign level      = count_q;
  assign overrun    = overrun_q;

`ifdef COM_RX_IRQ_EN
  localparam int                 IDLE_W      = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX    = IDLE_TIMEOUT[IDLE_W-1:0];
  localparam logic [DEPTH_LOG:0] THRESH_CNT  = IRQ_THRESH[DEPTH_LOG:0];

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              irq_q, irq_d;
  logic              idle_fired;

  assign idle_fired = (idle_q == IDLE_MAX);

  // Idle counter restarts on every push or when empty, saturating at the timeout
  always_comb begin
    idle_d = idle_q;
    if (push || is_empty)       idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
    irq_d = (count_q >= THRESH_CNT) || overrun_q || idle_fired;
  end

  // Registered interrupt request and idle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  // Interrupt feature absent: the tuning parameters have no effect here
  logic unused_irq_params;
  assign unused_irq_params = ^{IRQ_THRESH, IDLE_TIMEOUT};
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_com_rx_buffer.sv
// Scoreboard bench for com_rx_buffer. The driver issues directed vectors and
// pushes each byte it expects the FIFO to accept into a queue; a monitor pops
// and compares whenever the CPU side pops a presented byte.
// Interrupt scenarios run only when COM_RX_IRQ_EN is defined.
module tb_com_rx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_strobe;
  logic [7:0] rx_data;
  logic       rd_pop;
  logic       ovr_clr;
  logic [7:0] rd_data;
  logic       data_avail;
  logic       full;
  logic [4:0] level;
  logic       overrun;
  logic       irq;

`ifdef COM_RX_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int mcnt = 0;

  com_rx_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .rx_strobe  (rx_strobe),
    .rx_data    (rx_data),
    .rd_pop     (rd_pop),
    .ovr_clr    (ovr_clr),
    .rd_data    (rd_data),
    .data_avail (data_avail),
    .full       (full),
    .level      (level),
    .overrun    (overrun),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Apply one cycle of inputs (called at posedge+1), update the bench model
  task automatic step(input logic s, input logic [7:0] d, input logic p, input logic c);
    bit acc, pp;
    rx_strobe = s; rx_data = d; rd_pop = p; ovr_clr = c;
    acc = s && ((mcnt < 16) || p);
    pp  = p && (mcnt > 0);
    if (acc) exp_q.push_back(d);
    mcnt = mcnt + int'(acc) - int'(pp);
    @(posedge clk); #1;
    rx_strobe = 1'b0; rd_pop = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Monitor: every accepted CPU pop is checked against the scoreboard head
  always @(negedge clk) begin
    if (!rst && rd_pop && data_avail) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_data: got %0h expected none (scoreboard empty)", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_bad++;
          $display("FAIL pop_data: got %0h expected %0h", rd_data, e);
        end else begin
          $display("ok   pop_data: %0h", rd_data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rx_strobe = 1'b0; rx_data = 8'h00; rd_pop = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_avail", 32'(data_avail), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 1'b0;

    // Three bytes in, three out
    step(1, 8'h41, 0, 0); step(1, 8'h42, 0, 0); step(1, 8'h43, 0, 0);
    chk("abc_level", 32'(level), 3);
    chk("abc_head", 32'(rd_data), 32'h41);
    drain(3);
    chk("abc_avail_after", 32'(data_avail), 0);
    chk("abc_level_after", 32'(level), 0);
    chk("empty_rd_data", 32'(rd_data), 0);
    drain(1);  // pop on empty is ignored
    chk("pop_empty_level", 32'(level), 0);

    // Fill to 16, then one overrun
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 16);
    chk("fill_overrun", 32'(overrun), 0);
    step(1, 8'hFF, 0, 0);
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_level", 32'(level), 16);
    chk("ovr_head", 32'(rd_data), 32'h00);
    step(0, 8'h00, 0, 1);
    chk("ovr_clear", 32'(overrun), 0);
    idle(1);
    chk("fill_irq", 32'(irq), 32'(IRQ_ON));

    // Push and pop together on a full FIFO
    step(1, 8'hAA, 1, 0);
    chk("fullsim_level", 32'(level), 16);
    chk("fullsim_overrun", 32'(overrun), 0);
    drain(16);
    chk("fullsim_drained", 32'(level), 0);
    chk("scoreboard_empty1", 32'(exp_q.size()), 0);

    // Push and pop together on an empty FIFO
    step(1, 8'h55, 1, 0);
    chk("emptysim_level", 32'(level), 1);
    chk("emptysim_head", 32'(rd_data), 32'h55);
    drain(1);

    // Overrun set wins over a coincident clear
    for (int i = 0; i < 16; i++) step(1, 8'h80 + 8'(i), 0, 0);
    step(1, 8'hEE, 0, 0);
    chk("ovr2_set", 32'(overrun), 1);
    step(1, 8'hEF, 0, 1);
    chk("ovr2_set_wins", 32'(overrun), 1);
    step(0, 8'h00, 0, 1);
    chk("ovr2_cleared", 32'(overrun), 0);
    drain(16);
    chk("scoreboard_empty2", 32'(exp_q.size()), 0);

`ifdef COM_RX_IRQ_EN
    // Threshold interrupt
    for (int i = 0; i < 8; i++) step(1, 8'h10 + 8'(i), 0, 0);
    idle(1);
    chk("irq_thresh_on", 32'(irq), 1);
    drain(1);
    idle(1);
    chk("irq_thresh_off", 32'(irq), 0);
    drain(7);
    // Idle timeout interrupt
    step(1, 8'h77, 0, 0);
    idle(4096);
    chk("irq_idle_before", 32'(irq), 0);
    idle(1);
    chk("irq_idle_on", 32'(irq), 1);
    step(1, 8'h78, 0, 0);
    idle(1);
    chk("irq_idle_off", 32'(irq), 0);
    drain(2);
`endif

    // Reset mid-stream with overrun pending
    for (int i = 0; i < 16; i++) step(1, 8'h30 + 8'(i), 0, 0);
    step(1, 8'h99, 0, 0);
    chk("pre_rst_overrun", 32'(overrun), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_avail", 32'(data_avail), 0);
    chk("mid_rst_full", 32'(full), 0);
    chk("mid_rst_rd_data", 32'(rd_data), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_irq", 32'(irq), 0);
    exp_q.delete();
    mcnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 8'h5A, 0, 0);
    chk("post_rst_level", 32'(level), 1);
    drain(1);
    chk("scoreboard_empty3", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
